// File: rtl/mem_init_sink.sv
// Memory-side consumer of the init sweep bus: fills a register-file RAM, checks the sweep
// order/completeness, then opens the user ports. Define MEM_INIT_SINK_VERIFY_EN for a read-back VERIFY pass.
module mem_init_sink #(
  parameter int              DEPTH      = 32,
  parameter int              AW         = 5,
  parameter int              DW         = 32,
  parameter logic [DW-1:0]   FILL_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          initValid,
  input  logic [31:0]   initAddr,
  input  logic          initDone,
  input  logic          initDonePuls,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic [DW-1:0] rdData,
  output logic          rdValid,
  output logic          memReady,
  output logic          initErr,
  output logic [31:0]   errAddr,
  output logic [2:0]    dbgState
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_UNINIT = 3'd0,
    S_FILL   = 3'd1,
    S_CHECK  = 3'd2,
    S_READY  = 3'd3,
    S_FAULT  = 3'd4,
    S_VERIFY = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   exp_cnt_q, exp_cnt_d;
  logic            init_err_q, init_err_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic            mem_ready_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            sweep_start;
  logic            addr_in_range;
  logic            init_we;
  logic            user_en;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;
  logic            unused_puls;

`ifdef MEM_INIT_SINK_VERIFY_EN
  logic [CW-1:0]   ver_cnt_q, ver_cnt_d;
  logic [DW-1:0]   ver_data_q;
`endif

  // initDonePuls carries no meaning for the sink; the level initDone ends the sweep.
  assign unused_puls   = initDonePuls;
  assign sweep_start   = initValid && (initAddr == 32'd0);
  assign addr_in_range = initAddr < 32'(DEPTH);

  always_comb begin
    state_d    = state_q;
    exp_cnt_d  = exp_cnt_q;
    init_err_d = init_err_q;
    err_addr_d = err_addr_q;
    init_we    = 1'b0;
    user_en    = 1'b0;
`ifdef MEM_INIT_SINK_VERIFY_EN
    ver_cnt_d  = ver_cnt_q;
`endif
    case (state_q)
      S_UNINIT: begin
        if (sweep_start) begin
          state_d   = S_FILL;
          exp_cnt_d = CW'(1);
          init_we   = 1'b1;
        end
      end
      S_FILL: begin
        if (initValid && addr_in_range) begin
          init_we = 1'b1;
          if (initAddr == 32'(exp_cnt_q)) begin
            exp_cnt_d = exp_cnt_q + CW'(1);
          end else if (!init_err_q) begin
            init_err_d = 1'b1;
            err_addr_d = initAddr;
          end
        end
        if (initDone) state_d = S_CHECK;
      end
      S_CHECK: begin
        if ((exp_cnt_q == CW'(DEPTH)) && !init_err_q) begin
`ifdef MEM_INIT_SINK_VERIFY_EN
          state_d   = S_VERIFY;
          ver_cnt_d = '0;
`else
          state_d   = S_READY;
`endif
        end else begin
          init_err_d = 1'b1;
          if (!init_err_q) err_addr_d = 32'(exp_cnt_q);
          state_d    = S_FAULT;
        end
      end
`ifdef MEM_INIT_SINK_VERIFY_EN
      // ver_data_q holds word ver_cnt_q-1, so checking lags the read address by one cycle.
      S_VERIFY: begin
        if ((ver_cnt_q != '0) && (ver_data_q != FILL_VALUE)) begin
          init_err_d = 1'b1;
          err_addr_d = 32'(ver_cnt_q - CW'(1));
          state_d    = S_FAULT;
        end else if (ver_cnt_q == CW'(DEPTH)) begin
          state_d = S_READY;
        end else begin
          ver_cnt_d = ver_cnt_q + CW'(1);
        end
      end
`endif
      S_READY, S_FAULT: begin
        if (sweep_start) begin
          state_d    = S_FILL;
          exp_cnt_d  = CW'(1);
          init_we    = 1'b1;
          init_err_d = 1'b0;
          err_addr_d = '0;
        end else if (state_q == S_READY) begin
          user_en = 1'b1;
        end
      end
      default: state_d = S_UNINIT;
    endcase
  end

  // The sweep and the user port never write in the same cycle: user_en excludes init_we.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_waddr = initAddr[AW-1:0];
      mem_wdata = FILL_VALUE;
    end else if (user_en && wrEn) begin
      mem_we    = 1'b1;
      mem_waddr = wrAddr;
      mem_wdata = wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_UNINIT;
      exp_cnt_q   <= '0;
      init_err_q  <= 1'b0;
      err_addr_q  <= '0;
      mem_ready_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_cnt_q   <= exp_cnt_d;
      init_err_q  <= init_err_d;
      err_addr_q  <= err_addr_d;
      mem_ready_q <= (state_d == S_READY);
      rd_valid_q  <= user_en && rdEn;
      if (user_en && rdEn) rd_data_q <= mem_q[rdAddr];
    end
  end

`ifdef MEM_INIT_SINK_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ver_cnt_q  <= '0;
      ver_data_q <= '0;
    end else begin
      ver_cnt_q <= ver_cnt_d;
      if ((state_q == S_VERIFY) && (ver_cnt_q < CW'(DEPTH))) begin
        ver_data_q <= mem_q[ver_cnt_q[AW-1:0]];
      end
    end
  end
`endif

  assign rdData   = rd_data_q;
  assign rdValid  = rd_valid_q;
  assign memReady = mem_ready_q;
  assign initErr  = init_err_q;
  assign errAddr  = err_addr_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_mem_init_sink.sv
// Self-checking bench for mem_init_sink: table-driven user accesses, hand-built sweep
// sequences and randomized traffic against a behavioural memory / sweep-rule model.
module tb_mem_init_sink;

  localparam int          DEPTH = 32;
  localparam int          AW    = 5;
  localparam int          DW    = 32;
  localparam logic [31:0] FILL  = 32'h0;
`ifdef MEM_INIT_SINK_VERIFY_EN
  localparam int READY_LAT = DEPTH + 2;
`else
  localparam int READY_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          initValid, initDone, initDonePuls;
  logic [31:0]   initAddr;
  logic          wrEn, rdEn;
  logic [AW-1:0] wrAddr, rdAddr;
  logic [DW-1:0] wrData;
  logic [DW-1:0] rdData;
  logic          rdValid, memReady, initErr;
  logic [31:0]   errAddr;
  logic [2:0]    dbgState;

  mem_init_sink #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .FILL_VALUE(FILL)) dut (
    .clk(clk), .rst(rst),
    .initValid(initValid), .initAddr(initAddr), .initDone(initDone), .initDonePuls(initDonePuls),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(rdData), .rdValid(rdValid), .memReady(memReady),
    .initErr(initErr), .errAddr(errAddr), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   model_mem [DEPTH];
  logic [31:0]   last_rd = '0;
  int unsigned   sweep_q[$];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  ra;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    initValid = 0; initAddr = 0; initDone = 0; initDonePuls = 0;
    wrEn = 0; wrAddr = 0; wrData = 0; rdEn = 0; rdAddr = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic user_op(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rd, input logic [4:0] ra);
    wrEn = wr; wrAddr = wa; wrData = wd; rdEn = rd; rdAddr = ra;
    step();
    wrEn = 0; rdEn = 0;
  endtask

  // Sweep rule model: first in-range beat not equal to the running count is the error;
  // otherwise an incomplete count is reported at the count value.
  task automatic model_sweep(output bit err, output logic [31:0] ea);
    int unsigned cnt;
    cnt = 0; err = 0; ea = '0;
    foreach (sweep_q[i]) begin
      if (sweep_q[i] < DEPTH) begin
        if (!err && sweep_q[i] != cnt) begin
          err = 1; ea = sweep_q[i];
        end else if (sweep_q[i] == cnt) begin
          cnt++;
        end
      end
    end
    if (!err && cnt != DEPTH) begin
      err = 1; ea = cnt;
    end
  endtask

  task automatic do_sweep(input string tag);
    bit          exp_err;
    logic [31:0] exp_ea;
    model_sweep(exp_err, exp_ea);
    foreach (sweep_q[i]) begin
      initValid = 1; initAddr = sweep_q[i]; initDonePuls = (sweep_q[i] == DEPTH);
      step();
      if (i == 0) begin
        check({tag, "_first_beat_ready"}, memReady, 0);
        check({tag, "_first_beat_rdvalid"}, rdValid, 0);
        rdEn = 0; wrEn = 0;
      end
      if (sweep_q[i] < DEPTH) model_mem[sweep_q[i]] = FILL;
    end
    initValid = 0; initDonePuls = 0; initDone = 1;
    step();
    initDone = 0;
    check({tag, "_ready_in_check"}, memReady, 0);
    if (!exp_err) begin
      for (int k = 1; k < READY_LAT; k++) begin
        step();
        check({tag, "_ready_early"}, memReady, 0);
      end
    end
    step();
    check({tag, "_memReady"}, memReady, !exp_err);
    check({tag, "_initErr"}, initErr, exp_err);
    check({tag, "_errAddr"}, errAddr, exp_ea);
  endtask

  task automatic clean_sweep_q();
    sweep_q.delete();
    for (int a = 0; a <= DEPTH; a++) sweep_q.push_back(a);
  endtask

  task automatic read_check(input string name, input logic [4:0] ra);
    exp_q.push_back(model_mem[ra]);
    user_op(0, 0, 0, 1, ra);
    check({name, "_rdValid"}, rdValid, 1);
    check({name, "_rdData"}, rdData, exp_q.pop_front());
    last_rd = rdData;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    foreach (model_mem[i]) model_mem[i] = FILL;
    vecs[0] = '{1'b1, 5'd3,  32'hA5A5_0003, 1'b1, 5'd3,  1'b1, FILL};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b1, 32'hA5A5_0003};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 32'hA5A5_0003};
    vecs[3] = '{1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 5'd31, 1'b1, FILL};
    vecs[4] = '{1'b1, 5'd0,  32'h1234_5678, 1'b1, 5'd31, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 32'h1234_5678};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, FILL};

    idle();
    rst = 1;
    repeat (3) step();
    check("rst_memReady", memReady, 0);
    check("rst_rdValid", rdValid, 0);
    check("rst_rdData", rdData, 0);
    check("rst_initErr", initErr, 0);
    check("rst_errAddr", errAddr, 0);
    rst = 0;
    rdEn = 1; rdAddr = 5'd4;
    repeat (2) begin
      step();
      check("uninit_rdValid", rdValid, 0);
    end
    rdEn = 0;
    initValid = 1; initAddr = 32'd5;
    step();
    initValid = 0;
    check("uninit_nonzero_beat_err", initErr, 0);

    // nominal sweep with trailing beat at DEPTH
    clean_sweep_q();
    do_sweep("nominal");
    read_check("nominal_rd7", 5'd7);

    // table-driven user accesses
    foreach (vecs[i]) begin
      user_op(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].ra);
      if (vecs[i].wr) model_mem[vecs[i].wa] = vecs[i].wd;
      check($sformatf("vec%0d_rdValid", i), rdValid, vecs[i].exp_rv);
      check($sformatf("vec%0d_rdData", i), rdData, vecs[i].exp_rd);
    end
    last_rd = FILL;

    // randomized user traffic against the memory model
    for (int i = 0; i < 150; i++) begin
      logic wr, rd;
      logic [4:0] wa, ra;
      logic [31:0] wd;
      wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, DEPTH - 1)); ra = 5'($urandom_range(0, DEPTH - 1));
      wd = $urandom;
      if (rd) last_rd = model_mem[ra];
      if (wr) model_mem[wa] = wd;
      user_op(wr, wa, wd, rd, ra);
      check("rand_rdValid", rdValid, rd);
      check("rand_rdData", rdData, last_rd);
    end

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 rst = 1;
    #1;
    check("midrst_memReady", memReady, 0);
    check("midrst_rdValid", rdValid, 0);
    check("midrst_rdData", rdData, 0);
    check("midrst_initErr", initErr, 0);
    check("midrst_errAddr", errAddr, 0);
    step();
    rst = 0;
    rdEn = 1; rdAddr = 5'd3;
    step();
    rdEn = 0;
    check("postrst_rdValid", rdValid, 0);

    // skipped address 10
    sweep_q.delete();
    for (int a = 0; a <= DEPTH; a++) if (a != 10) sweep_q.push_back(a);
    do_sweep("skip10");
    check("skip10_errAddr_const", errAddr, 32'd11);
    user_op(1, 5'd3, 32'hFFFF_FFFF, 1, 5'd3);
    check("fault_rdValid", rdValid, 0);

    // short sweep, then clean recovery
    sweep_q.delete();
    for (int a = 0; a <= 20; a++) sweep_q.push_back(a);
    do_sweep("short");
    check("short_errAddr_const", errAddr, 32'd21);
    clean_sweep_q();
    do_sweep("recover");
    user_op(1, 5'd3, 32'hA5A5_0003, 0, 0);
    model_mem[3] = 32'hA5A5_0003;
    read_check("pre_reinit_rd3", 5'd3);

    // re-init from READY with a read on the dropping edge
    rdEn = 1; rdAddr = 5'd3;
    clean_sweep_q();
    do_sweep("reinit");
    read_check("reinit_rd3", 5'd3);

    // randomized sweeps: clean, one skipped address, or truncated
    for (int s = 0; s < 8; s++) begin
      int kind, k;
      kind = $urandom_range(0, 2);
      k    = $urandom_range(1, DEPTH - 1);
      sweep_q.delete();
      for (int a = 0; a <= DEPTH; a++) begin
        if (kind == 1 && a == k) continue;
        if (kind == 2 && a >= k) break;
        sweep_q.push_back(a);
      end
      do_sweep($sformatf("rsweep%0d", s));
      if (memReady) read_check("rsweep_rd", 5'($urandom_range(0, DEPTH - 1)));
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
